// File: rtl/sysid_arb_pkg.sv
// Shared types and helpers for the sysid read arbiter and other
// shared-slave arbiters built around round-robin grant selection.
package sysid_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic ADDR_ID        = 1'b0;
    localparam logic ADDR_TIMESTAMP = 1'b1;

    localparam int MAX_MASTERS = 8;

    // First requester at or after last+1, wrapping modulo n.
    function automatic logic [2:0] rr_next(
        input logic [7:0] req,
        input logic [2:0] last,
        input int         n
    );
        int   j;
        int   nn;
        logic found;
        rr_next = '0;
        found   = 1'b0;
        nn      = (n < 1) ? 1 : n;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            j = (int'(last) + k) % nn;
            if (k <= nn && !found && req[j[2:0]]) begin
                rr_next = j[2:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/sysid_read_arbiter_rr_grant_select.sv
// Combinational round-robin grant: one-hot and index form of the
// first requester after the last-granted master.
module rr_grant_select
    import sysid_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_valid,
    output logic [N-1:0]  o_grant_oh,
    output logic [IW-1:0] o_grant_idx
);

    logic [7:0] w_req8;
    logic [2:0] w_last3;
    logic [2:0] w_idx3;

    always_comb begin
        w_req8        = '0;
        w_req8[N-1:0] = i_req;
        w_last3       = 3'(i_last);
    end

    assign w_idx3      = rr_next(w_req8, w_last3, N);
    assign o_valid     = |i_req;
    assign o_grant_idx = IW'(w_idx3);

    always_comb begin
        o_grant_oh = '0;
        for (int i = 0; i < N; i++) begin
            o_grant_oh[i] = o_valid && (w_idx3 == 3'(i));
        end
    end

endmodule

// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter sharing one read-only sysid slave between
// several Avalon-MM read masters; all outputs come from registers.
module sysid_read_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int DATA_W        = 32,
    parameter int SLAVE_LATENCY = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_address,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [NUM_MASTERS*DATA_W-1:0] m_readdata,
    output logic                          s_address,
    input  logic [DATA_W-1:0]             s_readdata,
    output logic                          busy
);

    localparam int         IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [2:0] LAT = 3'(SLAVE_LATENCY);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IW-1:0]                 r_grant;
    logic [IW-1:0]                 w_grant_nxt;
    logic [IW-1:0]                 r_last;
    logic [IW-1:0]                 w_last_nxt;
    logic                          r_saddr;
    logic                          w_saddr_nxt;
    logic [2:0]                    r_cnt;
    logic [2:0]                    w_cnt_nxt;
    logic [NUM_MASTERS-1:0]        r_wait;
    logic [NUM_MASTERS-1:0]        w_wait_nxt;
    logic [NUM_MASTERS*DATA_W-1:0] r_rdata;
    logic [NUM_MASTERS*DATA_W-1:0] w_rdata_nxt;
    logic                          r_busy;

    logic                   w_any;
    logic [NUM_MASTERS-1:0] w_sel_oh;
    logic [IW-1:0]          w_sel_idx;

    rr_grant_select #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_sel (
        .i_req       (m_read),
        .i_last      (r_last),
        .o_valid     (w_any),
        .o_grant_oh  (w_sel_oh),
        .o_grant_idx (w_sel_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= '0;
            r_saddr <= ADDR_ID;
            r_cnt   <= '0;
            r_wait  <= '1;
            r_rdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_saddr <= w_saddr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wait  <= w_wait_nxt;
            r_rdata <= w_rdata_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Waitrequest and data are set up on the edge entering RESPOND
    // so the master sees them registered during that single cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_saddr_nxt = r_saddr;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = '1;
        w_rdata_nxt = r_rdata;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_nxt = w_sel_idx;
                    w_saddr_nxt = |(m_address & w_sel_oh);
                    w_cnt_nxt   = LAT;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_state_nxt         = RESPOND;
                    w_wait_nxt[r_grant] = 1'b0;
                    w_rdata_nxt[int'(r_grant)*DATA_W +: DATA_W] = s_readdata;
                end
            end
            RESPOND: begin
                w_last_nxt  = r_grant;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign m_waitrequest = r_wait;
    assign m_readdata    = r_rdata;
    assign s_address     = r_saddr;
    assign busy          = r_busy;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Scoreboard bench: random master traffic, transaction-level model of
// grant order and completion timing, monitor checks every cycle.
module tb_sysid_read_arbiter;

    localparam int NM  = 3;
    localparam int LAT = 2;
    localparam int DW  = 32;
    localparam logic [DW-1:0] TS_WORD = 32'h5B51BD68;

    localparam int M_RAND  = 0;
    localparam int M_CONT  = 1;
    localparam int M_DRAIN = 2;

    typedef struct {
        int            m;
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NM-1:0]    m_read = '0;
    logic [NM-1:0]    m_address = '0;
    logic [NM-1:0]    m_waitrequest;
    logic [NM*DW-1:0] m_readdata;
    logic             s_address;
    logic [DW-1:0]    s_readdata;
    logic             busy;

    sysid_read_arbiter #(
        .NUM_MASTERS   (NM),
        .DATA_W        (DW),
        .SLAVE_LATENCY (LAT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .m_read        (m_read),
        .m_address     (m_address),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .s_address     (s_address),
        .s_readdata    (s_readdata),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Slave: data reflects the address presented LAT cycles earlier.
    logic a_hist [0:7];
    always @(posedge clock) begin
        a_hist[0] <= s_address;
        for (int k = 1; k < 8; k++) a_hist[k] <= a_hist[k-1];
    end

    function automatic logic [DW-1:0] slave_word(input logic a);
        return a ? TS_WORD : '0;
    endfunction

    assign s_readdata = slave_word((LAT == 0) ? s_address
                                              : a_hist[(LAT == 0) ? 0 : LAT-1]);

    exp_t          q[$];
    int            cyc = 0;
    int            free_at = 0;
    int            gcyc = -100;
    int            last_g = 0;
    int            rst_cyc = -1;
    int            grant_evt = -1;
    logic          exp_saddr = 1'b0;
    logic [DW-1:0] exp_data [NM];
    int            errors = 0;
    int            checks = 0;
    int            mode = M_RAND;
    logic          viol = 1'b0;
    logic          want_rst = 1'b0;
    logic [NM-1:0] orphan = '0;
    int            cnt [NM];
    int            tot = 0;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic int pick(input logic [NM-1:0] req, input int last);
        for (int k = 1; k <= NM; k++) begin
            if (req[(last + k) % NM]) return (last + k) % NM;
        end
        return -1;
    endfunction

    // Reference model: one transfer at a time, grant in rotation order,
    // completion 2+LAT cycles after the IDLE cycle that saw the request.
    initial begin
        exp_t e;
        int   g;
        forever begin
            @(posedge clock);
            grant_evt = -1;
            if (reset) begin
                q.delete();
                free_at = cyc + 1;
                gcyc    = -100;
                last_g  = 0;
                rst_cyc = cyc + 1;
            end else if (cyc >= free_at && m_read != '0) begin
                g      = pick(m_read, last_g);
                e.m    = g;
                e.cyc  = cyc + 2 + LAT;
                e.data = slave_word(m_address[g]);
                q.push_back(e);
                free_at   = cyc + 3 + LAT;
                gcyc      = cyc;
                last_g    = g;
                exp_saddr = m_address[g];
                grant_evt = g;
            end
            cyc++;
        end
    end

    // Monitor
    initial begin
        exp_t             e;
        logic [NM-1:0]    exp_w;
        logic [NM*DW-1:0] exp_rd;
        logic             exp_busy;
        for (int i = 0; i < NM; i++) begin
            exp_data[i] = '0;
            cnt[i]      = 0;
        end
        forever begin
            @(negedge clock);
            if (cyc >= 1) begin
                if (rst_cyc == cyc) begin
                    for (int i = 0; i < NM; i++) exp_data[i] = '0;
                end
                exp_w = '1;
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    exp_w[e.m]  = 1'b0;
                    exp_data[e.m] = e.data;
                end
                for (int i = 0; i < NM; i++) exp_rd[i*DW +: DW] = exp_data[i];
                exp_busy = (cyc > gcyc) && (cyc < free_at);
                chk("waitrequest", 128'(m_waitrequest), 128'(exp_w));
                chk("readdata", 128'(m_readdata), 128'(exp_rd));
                chk("busy", 128'(busy), 128'(exp_busy));
                if (exp_busy) chk("s_address", 128'(s_address), 128'(exp_saddr));
                for (int i = 0; i < NM; i++) begin
                    if (m_waitrequest[i] === 1'b0) begin
                        cnt[i]++;
                        tot++;
                    end
                end
            end
        end
    end

    // Master / reset driver
    initial begin
        logic [NM-1:0] wsnap;
        logic          rst_now;
        int            g;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        forever begin
            @(negedge clock);
            wsnap = m_waitrequest;
            @(posedge clock);
            #1;
            rst_now = 1'b0;
            if (reset) begin
                reset = 1'b0;
            end else if (want_rst && grant_evt >= 0) begin
                reset    = 1'b1;
                want_rst = 1'b0;
                orphan   = '0;
                rst_now  = 1'b1;
            end
            for (int i = 0; i < NM; i++) begin
                if (orphan[i]) begin
                    if (!wsnap[i]) orphan[i] = 1'b0;
                end else if (m_read[i]) begin
                    if (!wsnap[i]) begin
                        if (mode == M_CONT) begin
                            m_address[i] = 1'($urandom_range(0, 1));
                        end else if (mode == M_RAND && $urandom_range(0, 1) == 1) begin
                            m_address[i] = 1'($urandom_range(0, 1));
                        end else begin
                            m_read[i] = 1'b0;
                        end
                    end
                end else if (mode == M_CONT ||
                             (mode == M_RAND && $urandom_range(0, 3) == 0)) begin
                    m_read[i]    = 1'b1;
                    m_address[i] = 1'($urandom_range(0, 1));
                end
            end
            if (viol && !rst_now && grant_evt >= 0 && $urandom_range(0, 1) == 1) begin
                g = grant_evt;
                m_address[g] = ~m_address[g];
                if ($urandom_range(0, 1) == 1) begin
                    m_read[g] = 1'b0;
                    orphan[g] = 1'b1;
                end
            end
        end
    end

    task automatic drain(input string name);
        int k;
        mode = M_DRAIN;
        k = 0;
        while (k < 400 && !(m_read == '0 && orphan == '0 &&
                             q.size() == 0 && busy == 1'b0)) begin
            @(posedge clock);
            k++;
        end
        chk(name, 128'(k < 400), 128'(1));
    endtask

    initial begin
        int base_cnt [NM];
        int base_tot;
        int k;
        mode = M_RAND;
        repeat (400) @(posedge clock);
        viol = 1'b1;
        repeat (400) @(posedge clock);
        viol = 1'b0;
        for (int r = 0; r < 4; r++) begin
            want_rst = 1'b1;
            k = 0;
            while (k < 300 && want_rst) begin
                @(posedge clock);
                k++;
            end
            chk("rst_inject_timeout", 128'(want_rst), 128'(0));
            repeat (60) @(posedge clock);
        end
        drain("drain1_timeout");
        for (int i = 0; i < NM; i++) base_cnt[i] = cnt[i];
        base_tot = tot;
        mode = M_CONT;
        k = 0;
        while (k < 1000 && tot - base_tot < 10 * NM) begin
            @(posedge clock);
            k++;
        end
        chk("fair_total", 128'(tot - base_tot), 128'(10 * NM));
        for (int i = 0; i < NM; i++) begin
            chk("fair_count", 128'(cnt[i] - base_cnt[i]), 128'(10));
        end
        mode = M_RAND;
        repeat (300) @(posedge clock);
        drain("drain2_timeout");
        repeat (5) @(posedge clock);
        chk("queue_empty", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Shares one read-only system-ID slave between NUM_MASTERS Avalon-MM read masters, e.g. the Nios II data master and a debug/JTAG master.
- The slave is a 1-bit-address register pair: word 0 is the ID, word 1 is the build timestamp.
- The arbiter serialises reads with round-robin grant and holds each master with waitrequest until its data is returned.
- It sits in the Qsys fabric between the masters and the sysid control slave.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8).
- DATA_W, 32, readdata width.
- SLAVE_LATENCY, 0, extra clock cycles between slave address presentation and valid s_readdata (0..7).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- m_read  input  NUM_MASTERS  per-master read request; bit i belongs to master i.
- m_address  input  NUM_MASTERS  per-master word address (0 = ID, 1 = timestamp).
- m_waitrequest  output  NUM_MASTERS  per-master stall; low for exactly the completing cycle.
- m_readdata  output  NUM_MASTERS*DATA_W  per-master data; slice i = bits [i*DATA_W +: DATA_W].
- s_address  output  1  address driven to the sysid slave.
- s_readdata  input  DATA_W  data from the sysid slave.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, m_waitrequest all 1, m_readdata all 0, s_address=0, rr pointer=0, latency counter=0, busy=0. Reset asserted mid-transaction aborts it. No completion is signalled for the aborted read; the master keeps its read asserted and is re-served after reset.
- FSM: IDLE -> ISSUE -> RESPOND -> IDLE.
- IDLE:
  - If any m_read bit is 1, select the grant by round-robin. Search starts at index (last_grant+1) mod NUM_MASTERS and takes the first set bit.
  - Latch the grant index and m_address[grant] into s_address.
  - Load the counter with SLAVE_LATENCY and go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - s_address is held stable.
  - If counter != 0, decrement.
  - If counter == 0, capture s_readdata into the data register and go to RESPOND.
- RESPOND (one cycle):
  - m_waitrequest[grant]=0; m_readdata slice[grant]=captured data.
  - last_grant <= grant; next state is IDLE.
- Latency: a request first seen in IDLE at cycle t completes (waitrequest low) at cycle t+2+SLAVE_LATENCY. Minimum issue interval is 3+SLAVE_LATENCY cycles per transfer.
- Non-granted masters: waitrequest held at 1. Their m_readdata slices hold the last value returned to them (0 after reset). Only the granted slice updates, and only in RESPOND.
- Address or read changes by the granted master during ISSUE (a protocol violation) are ignored. The latched address is used and the transfer completes normally.
- If m_read[grant] is deasserted during ISSUE, RESPOND still occurs and the data is discarded by the master. No hang.
- Simultaneous requests from all masters: each master is served once before any master is served twice (strict rotation).
- NUM_MASTERS=1: the pointer is fixed at 0 and the FSM is unchanged.
- Width rule: the grant index is max(1, $clog2(NUM_MASTERS)) bits. Pointer increment wraps from NUM_MASTERS-1 to 0, including non-power-of-2 counts.
- No combinational path from m_read to m_waitrequest; all outputs are registered.

Decomposition:
- Shared package sysid_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESPOND};
  - localparam ADDR_ID=0, ADDR_TIMESTAMP=1;
  - function rr_next(req, last) returning the grant index.
- One natural sub-module: rr_grant_select. It is combinational round-robin selection from the request vector and the last-grant pointer, giving a one-hot grant and an index. It is reused by other shared-slave arbiters.

Test Plan:
- Slave model for all scenarios: returns 0x00000000 at address 0 and 0x5B51BD68 at address 1; SLAVE_LATENCY=0 unless stated.
- Single read: master0 reads address 1 at cycle 5 -> m_waitrequest[0]=0 at cycle 7 only, m_readdata slice0=0x5B51BD68, busy high cycles 6-7.
- Contention: both masters read at the same cycle with last_grant=0 -> master1 served first, then master0. Completions are 3 cycles apart with correct per-slice data (addresses 0 and 1).
- Fairness: NUM_MASTERS=3, all requesting continuously for 30 transfers -> grant sequence 1,2,0,1,2,0,... and each master completes exactly 10 times.
- Latency: SLAVE_LATENCY=3, master0 reads address 0 -> completion at t+5 with data 0x00000000; s_address stable throughout ISSUE.
- Reset mid-operation: reset asserted during ISSUE -> next cycle IDLE, all waitrequest=1, readdata=0, busy=0. After reset deasserts, the pending read completes 2 cycles later.
- Protocol violation: the granted master drops m_read and toggles m_address during ISSUE -> RESPOND occurs once using the originally latched address; the FSM returns to IDLE with no stall.
